// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipeline_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } ctrl_state_t;

    // One in-flight destination tracked by the scoreboard.
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dst;
        logic             wren;
    } slot_t;

    localparam slot_t EMPTY_SLOT = '{valid: 1'b0, dst: ZERO_REG, wren: 1'b0};

    // A slot blocks a read only if it will really write a non-zero register.
    function automatic logic slot_hit(slot_t s, logic [REG_W-1:0] src);
        return s.valid && s.wren && (s.dst != ZERO_REG) && (s.dst == src);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Decode-stage hazard request and stall/flush response bundle between datapath and controller.
interface pipeline_ctrl_if;
    import pipeline_pkg::*;

    logic             fd_valid;
    logic [REG_W-1:0] fd_rs1;
    logic [REG_W-1:0] fd_rs2;
    logic             fd_rs1_used;
    logic             fd_rs2_used;
    logic [REG_W-1:0] fd_write_reg;
    logic             fd_reg_wrenable;
    logic             should_jump;

    logic             pc_stall;
    logic             fd_stall;
    logic             ex_bubble;
    logic             flush_fd;
    logic             flush_ex;
    logic             flush_mem;

    modport master (
        output fd_valid, fd_rs1, fd_rs2, fd_rs1_used, fd_rs2_used,
               fd_write_reg, fd_reg_wrenable, should_jump,
        input  pc_stall, fd_stall, ex_bubble, flush_fd, flush_ex, flush_mem
    );

    modport slave (
        input  fd_valid, fd_rs1, fd_rs2, fd_rs1_used, fd_rs2_used,
               fd_write_reg, fd_reg_wrenable, should_jump,
        output pc_stall, fd_stall, ex_bubble, flush_fd, flush_ex, flush_mem
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // NOTE: clocked state is always assigned with <= so every register samples pre-edge values.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller: stalls decode on RAW hazards against EX/MEM,
// flushes younger stages on a taken jump, and keeps saturating perf counters.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    pipeline_ctrl_if.slave   bus,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

    ctrl_state_t state, state_nxt;
    logic [1:0]  flush_cnt, flush_cnt_nxt;
    slot_t       slot_ex, slot_mem;
    logic        hazard;
    logic        flush;
    logic        stall;
    logic        rs1_hit, rs2_hit;

    // No forwarding and no register-file write-through, so both slots block a read.
    assign rs1_hit = slot_hit(slot_ex, bus.fd_rs1) || slot_hit(slot_mem, bus.fd_rs1);
    assign rs2_hit = slot_hit(slot_ex, bus.fd_rs2) || slot_hit(slot_mem, bus.fd_rs2);
    assign hazard  = bus.fd_valid && ((bus.fd_rs1_used && rs1_hit) || (bus.fd_rs2_used && rs2_hit));

    // Reset forces the flush path so the pipe stays clean until the first RUN cycle.
    assign flush = reset || bus.should_jump || ((state == FLUSH) && (flush_cnt != 2'd0));
    assign stall = hazard && !flush;

    assign bus.pc_stall  = stall;
    assign bus.fd_stall  = stall;
    assign bus.ex_bubble = stall;
    assign bus.flush_fd  = flush;
    assign bus.flush_ex  = flush;
    assign bus.flush_mem = flush;
    assign ctrl_state    = state;

    // NOTE: defaults first so every path assigns the next-state signals and no latch is inferred.
    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        if (bus.should_jump) begin
            state_nxt     = FLUSH;
            flush_cnt_nxt = FLUSH_LOAD;
        end else begin
            case (state)
                RUN:     if (hazard) state_nxt = STALL;
                STALL:   if (!hazard) state_nxt = RUN;
                FLUSH: begin
                    if (flush_cnt == 2'd0) state_nxt = RUN;
                    else                   flush_cnt_nxt = flush_cnt - 2'd1;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state     <= RUN;
            flush_cnt <= 2'd0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    // A stalled decode enters EX as a bubble; a flush empties both slots at once.
    always_ff @(posedge CLOCK_50) begin
        if (flush) begin
            slot_ex  <= EMPTY_SLOT;
            slot_mem <= EMPTY_SLOT;
        end else begin
            slot_mem <= slot_ex;
            slot_ex  <= '{valid: bus.fd_valid && !stall,
                          dst:   bus.fd_write_reg,
                          wren:  bus.fd_reg_wrenable};
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .inc      (stall),
        .count    (stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .inc      (bus.should_jump),
        .count    (flush_events)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench: two controller instances driven identically, checked against
// an in-flight-register / flush-window reference model.
module tb_pipeline_ctrl;
    import pipeline_pkg::*;

    localparam int FC_A = 1;
    localparam int CW_A = 16;
    localparam int FC_B = 3;
    localparam int CW_B = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipeline_ctrl_if bus_a ();
    pipeline_ctrl_if bus_b ();

    logic [1:0]      state_a, state_b;
    logic [CW_A-1:0] sc_a, fe_a;
    logic [CW_B-1:0] sc_b, fe_b;

    pipeline_ctrl #(.FLUSH_CYCLES(FC_A), .CNT_W(CW_A)) dut_a (
        .CLOCK_50     (clk),
        .reset        (reset),
        .bus          (bus_a),
        .ctrl_state   (state_a),
        .stall_cycles (sc_a),
        .flush_events (fe_a)
    );

    pipeline_ctrl #(.FLUSH_CYCLES(FC_B), .CNT_W(CW_B)) dut_b (
        .CLOCK_50     (clk),
        .reset        (reset),
        .bus          (bus_b),
        .ctrl_state   (state_b),
        .stall_cycles (sc_b),
        .flush_events (fe_b)
    );

    typedef struct {
        bit rst; bit valid; int rs1; int rs2; bit u1; bit u2; int wr; bit wren; bit jump;
    } stim_t;

    typedef struct {
        bit known; bit stall; bit flush; int state; int sc; int fe;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: destinations issued in the last two accepted slots, and
    // the cycle of the most recent accepted jump.
    int inflight [2][2];
    int last_jump [2];
    bit prev_stall [2];
    bit known [2];
    int sc [2];
    int fe [2];
    int fcyc [2];
    int cmax [2];
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, expv, $time);
        end
    endtask

    function automatic bit in_flight(input int d, input int r);
        return (r != 0) && ((inflight[d][0] == r) || (inflight[d][1] == r));
    endfunction

    task automatic model_step(input int d, input stim_t s, output exp_t e);
        bit hz, fl, st;
        e.known = known[d];
        if (cyc > last_jump[d] && cyc <= last_jump[d] + fcyc[d]) e.state = 2;
        else if (prev_stall[d])                                  e.state = 1;
        else                                                     e.state = 0;
        e.sc = sc[d];
        e.fe = fe[d];
        hz = s.valid && ((s.u1 && in_flight(d, s.rs1)) || (s.u2 && in_flight(d, s.rs2)));
        fl = s.rst || s.jump || (cyc > last_jump[d] && cyc < last_jump[d] + fcyc[d]);
        st = hz && !fl;
        e.stall = st;
        e.flush = fl;
        if (s.rst) begin
            inflight[d][0] = 0;
            inflight[d][1] = 0;
            last_jump[d]   = -100;
            prev_stall[d]  = 1'b0;
            sc[d]          = 0;
            fe[d]          = 0;
            known[d]       = 1'b1;
        end else begin
            if (fl) begin
                inflight[d][0] = 0;
                inflight[d][1] = 0;
            end else begin
                inflight[d][1] = inflight[d][0];
                inflight[d][0] = (s.valid && !st && s.wren) ? s.wr : 0;
            end
            if (s.jump) last_jump[d] = cyc;
            prev_stall[d] = st;
            if (st && sc[d] < cmax[d])     sc[d]++;
            if (s.jump && fe[d] < cmax[d]) fe[d]++;
        end
    endtask

    task automatic drive(input stim_t s);
        exp_t ea, eb;
        @(posedge clk);
        #1;
        reset                 = s.rst;
        bus_a.fd_valid        = s.valid;
        bus_a.fd_rs1          = REG_W'(s.rs1);
        bus_a.fd_rs2          = REG_W'(s.rs2);
        bus_a.fd_rs1_used     = s.u1;
        bus_a.fd_rs2_used     = s.u2;
        bus_a.fd_write_reg    = REG_W'(s.wr);
        bus_a.fd_reg_wrenable = s.wren;
        bus_a.should_jump     = s.jump;
        bus_b.fd_valid        = s.valid;
        bus_b.fd_rs1          = REG_W'(s.rs1);
        bus_b.fd_rs2          = REG_W'(s.rs2);
        bus_b.fd_rs1_used     = s.u1;
        bus_b.fd_rs2_used     = s.u2;
        bus_b.fd_write_reg    = REG_W'(s.wr);
        bus_b.fd_reg_wrenable = s.wren;
        bus_b.should_jump     = s.jump;
        model_step(0, s, ea);
        model_step(1, s, eb);
        q_a.push_back(ea);
        q_b.push_back(eb);
        cyc++;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{rst: 1'b0, valid: 1'b0, rs1: 0, rs2: 0, u1: 1'b0, u2: 1'b0, wr: 0, wren: 1'b0, jump: 1'b0};
        return s;
    endfunction

    function automatic stim_t ins(input int wr, input bit wren, input int rs1, input bit u1,
                                  input int rs2, input bit u2);
        stim_t s;
        s = '{rst: 1'b0, valid: 1'b1, rs1: rs1, rs2: rs2, u1: u1, u2: u2, wr: wr, wren: wren, jump: 1'b0};
        return s;
    endfunction

    task automatic idles(input int n);
        for (int i = 0; i < n; i++) drive(idle());
    endtask

    // Monitor: one expected entry per cycle, compared on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                check("a.pc_stall",  32'(bus_a.pc_stall),  int'(e.stall));
                check("a.fd_stall",  32'(bus_a.fd_stall),  int'(e.stall));
                check("a.ex_bubble", 32'(bus_a.ex_bubble), int'(e.stall));
                check("a.flush_fd",  32'(bus_a.flush_fd),  int'(e.flush));
                check("a.flush_ex",  32'(bus_a.flush_ex),  int'(e.flush));
                check("a.flush_mem", 32'(bus_a.flush_mem), int'(e.flush));
                if (e.known) begin
                    check("a.ctrl_state",   32'(state_a), e.state);
                    check("a.stall_cycles", 32'(sc_a),    e.sc);
                    check("a.flush_events", 32'(fe_a),    e.fe);
                end
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                check("b.pc_stall",  32'(bus_b.pc_stall),  int'(e.stall));
                check("b.fd_stall",  32'(bus_b.fd_stall),  int'(e.stall));
                check("b.ex_bubble", 32'(bus_b.ex_bubble), int'(e.stall));
                check("b.flush_fd",  32'(bus_b.flush_fd),  int'(e.flush));
                check("b.flush_ex",  32'(bus_b.flush_ex),  int'(e.flush));
                check("b.flush_mem", 32'(bus_b.flush_mem), int'(e.flush));
                if (e.known) begin
                    check("b.ctrl_state",   32'(state_b), e.state);
                    check("b.stall_cycles", 32'(sc_b),    e.sc);
                    check("b.flush_events", 32'(fe_b),    e.fe);
                end
            end
        end
    end

    initial begin
        stim_t s;
        fcyc = '{FC_A, FC_B};
        cmax = '{(1 << CW_A) - 1, (1 << CW_B) - 1};
        for (int d = 0; d < 2; d++) begin
            inflight[d][0] = 0;
            inflight[d][1] = 0;
            last_jump[d]   = -100;
            prev_stall[d]  = 1'b0;
            known[d]       = 1'b0;
            sc[d]          = 0;
            fe[d]          = 0;
        end
        reset                 = 1'b1;
        bus_a.fd_valid        = 1'b0;
        bus_a.fd_rs1          = '0;
        bus_a.fd_rs2          = '0;
        bus_a.fd_rs1_used     = 1'b0;
        bus_a.fd_rs2_used     = 1'b0;
        bus_a.fd_write_reg    = '0;
        bus_a.fd_reg_wrenable = 1'b0;
        bus_a.should_jump     = 1'b0;
        bus_b.fd_valid        = 1'b0;
        bus_b.fd_rs1          = '0;
        bus_b.fd_rs2          = '0;
        bus_b.fd_rs1_used     = 1'b0;
        bus_b.fd_rs2_used     = 1'b0;
        bus_b.fd_write_reg    = '0;
        bus_b.fd_reg_wrenable = 1'b0;
        bus_b.should_jump     = 1'b0;

        // Reset for two cycles, then release.
        s = idle(); s.rst = 1'b1;
        drive(s); drive(s);
        idles(2);

        // Back-to-back dependence: two stall cycles, decode holds the reader.
        drive(ins(5, 1, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) drive(ins(6, 1, 5, 1, 0, 0));
        idles(3);

        // One instruction apart via rs2: one stall cycle.
        drive(ins(5, 1, 0, 0, 0, 0));
        drive(ins(7, 1, 1, 1, 2, 1));
        for (int i = 0; i < 2; i++) drive(ins(8, 1, 0, 0, 5, 1));
        idles(3);

        // Two instructions apart: no stall.
        drive(ins(5, 1, 0, 0, 0, 0));
        drive(ins(7, 1, 1, 1, 2, 1));
        drive(ins(8, 1, 3, 1, 4, 1));
        drive(ins(9, 1, 5, 1, 0, 0));
        idles(3);

        // Register 0 never hazards.
        drive(ins(0, 1, 0, 0, 0, 0));
        drive(ins(9, 1, 0, 1, 0, 1));
        idles(3);

        // Jump in the first stall cycle wins over the hazard.
        drive(ins(5, 1, 0, 0, 0, 0));
        s = ins(6, 1, 5, 1, 0, 0); s.jump = 1'b1;
        drive(s);
        idles(2);
        drive(ins(6, 1, 5, 1, 0, 0));
        idles(3);

        // Jump pulses on consecutive cycles (reload of the flush window).
        s = idle(); s.jump = 1'b1;
        drive(s); drive(s);
        idles(6);

        // Reset in the middle of a stall; the same reader then proceeds.
        drive(ins(5, 1, 0, 0, 0, 0));
        drive(ins(6, 1, 5, 1, 0, 0));
        s = ins(6, 1, 5, 1, 0, 0); s.rst = 1'b1;
        drive(s);
        drive(ins(6, 1, 5, 1, 0, 0));
        idles(3);

        // Self-dependent chain: sustained stalls drive the narrow counter into saturation.
        for (int i = 0; i < 450; i++) drive(ins(5, 1, 5, 1, 0, 0));
        idles(3);

        // Randomized traffic over a small register set to make hazards frequent.
        for (int i = 0; i < 1500; i++) begin
            s.rst   = ($urandom_range(0, 99) == 0);
            s.valid = ($urandom_range(0, 9) < 7);
            s.rs1   = int'($urandom_range(0, 3));
            s.rs2   = int'($urandom_range(0, 3));
            s.u1    = $urandom_range(0, 1) == 1;
            s.u2    = $urandom_range(0, 1) == 1;
            s.wr    = int'($urandom_range(0, 3));
            s.wren  = ($urandom_range(0, 3) != 0);
            s.jump  = ($urandom_range(0, 24) == 0);
            drive(s);
        end
        idles(3);

        repeat (2) @(posedge clk);
        check("queue_drain", 32'(q_a.size() + q_b.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and sequencing controller for the five-stage pipelined CPU (fetch/decode, EX pipeline regs, execute, MEM pipeline regs, mem/writeback). It keeps its own scoreboard of destination registers in flight in the EX and MEM stages. It stalls fetch/decode and injects bubbles on read-after-write hazards, since the datapath has no forwarding. It flushes the younger stages when mem/writeback resolves a taken jump, and it keeps saturating performance counters.

## Interface
- REG_W, 5, register-address width (matches write_reg fields)
- FLUSH_CYCLES, 1, cycles flush is held after a taken jump (legal 1..3)
- CNT_W, 16, width of performance counters
- CLOCK_50  in  1  single system clock, all state on rising edge
- reset  in  1  synchronous, active-high; sampled on CLOCK_50 rising edge
- fd_valid  in  1  decode stage holds a real instruction this cycle
- fd_rs1, fd_rs2  in  REG_W each  source register addresses in decode
- fd_rs1_used, fd_rs2_used  in  1 each  source actually read by the instruction
- fd_write_reg  in  REG_W  destination of the decoding instruction
- fd_reg_wrenable  in  1  decoding instruction writes the register file
- should_jump  in  1  taken jump resolved in mem/writeback this cycle
- pc_stall  out  1  hold PC
- fd_stall  out  1  hold fetch/decode outputs
- ex_bubble  out  1  load NOP (all enables 0) into EX pipeline regs
- flush_fd, flush_ex, flush_mem  out  1 each  squash contents of that stage
- ctrl_state  out  2  0=RUN, 1=STALL, 2=FLUSH
- stall_cycles  out  CNT_W  saturating count of cycles with pc_stall=1
- flush_events  out  CNT_W  saturating count of should_jump pulses accepted

## Operation
- Scoreboard: two slots, slot_ex and slot_mem, each {valid, reg, wren}. Each edge: slot_mem <= slot_ex, slot_ex <= decode entry. Decode entry is {fd_valid & ~stall & ~flush, fd_write_reg, fd_reg_wrenable}. A bubble or flush writes valid=0.
- A slot is live when valid & wren & reg!=0.
- Hazard = fd_valid & ((fd_rs1_used & rs1 matches a live slot) | (fd_rs2_used & rs2 matches a live slot)). Register 0 never hazards.
- Both slots are checked. The register file writes at the end of mem/writeback and has no write-through, so a MEM-slot match stalls too. Worst-case stall is 2 cycles.
- On a hazard: pc_stall=fd_stall=ex_bubble=1.
- FSM:
  - RUN: hazard goes to STALL. should_jump goes to FLUSH.
  - STALL: stays while hazard. Goes to RUN when the hazard clears. should_jump goes to FLUSH.
  - FLUSH: a down-counter is loaded with FLUSH_CYCLES-1 on entry. Returns to RUN when it reaches 0. A new should_jump while in FLUSH reloads the counter.
- Flush outputs: flush_fd = flush_ex = flush_mem = should_jump | (state==FLUSH & count!=0). Both slots are invalidated on the same edge.
- Priority: flush over stall. A hazard in a should_jump cycle gives pc_stall=0, and no STALL state is entered.
- Counters: increment by 1 per qualifying cycle and saturate at all ones. flush_events counts should_jump cycles only, including reloads.

## Timing
- Hazard, stall and flush outputs are combinational from the current inputs and registered state (Mealy), so they are valid in the same cycle. Slots, FSM and counters update on the edge.
- Reset asserted: slots invalid, ctrl_state=RUN, counters=0, pc_stall=fd_stall=ex_bubble=0, all flush outputs=1. This holds the pipe clean during reset.
- Reset takes precedence over every other input, including mid-stall and mid-flush. The first cycle after reset deasserts is RUN with an empty scoreboard.
- Back-to-back dependent instructions: 2 stall cycles. Dependence on the instruction two ahead: 1 stall cycle. Three ahead: 0.

## Structure
- Shared package pipeline_pkg holds:
  - the state encoding RUN/STALL/FLUSH;
  - the scoreboard slot struct {valid, reg, wren};
  - REG_W and the constant ZERO_REG=0.
- One natural sub-module, sat_counter (CNT_W, inc, reset), instantiated twice for the performance counters.

## Test plan
- reset=1 for 2 cycles, then release with fd_valid=0 -> all flush outputs 1 during reset, then 0. ctrl_state=0, counters 0.
- Write r5, then immediately read r5 (rs1=5) -> pc_stall=1 for exactly 2 cycles with ex_bubble=1. Then RUN. stall_cycles=2.
- Write r5, one independent instruction, then read r5 via rs2 -> 1 stall cycle. Three apart -> none. Write r0, then read r0 -> no stall.
- Dependent pair stalled, with should_jump=1 in the first stall cycle -> pc_stall=0 and flush_* =1 that cycle. Slots cleared, state FLUSH then RUN. flush_events=1.
- FLUSH_CYCLES=3, should_jump pulses at t and t+1 -> flush held t..t+3, flush_events=2.
- Force a hazard for 70000 cycles with CNT_W=16 -> stall_cycles saturates at 65535.
- Reset asserted mid-stall -> next cycle ctrl_state=RUN, scoreboard empty, the same read proceeds with no stall.
